// File: rtl/snes_pad_if.sv
// SNES pad reader bundle: host-side controls/results plus pad pins.
// slave = reader side, master = host/pad side.
interface snes_pad_if;
    logic        enable;
    logic        pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic        busy;
    logic [15:0] con_state;
    logic        con_update;

    modport slave (
        input  enable,
        input  pad_data,
        output pad_latch,
        output pad_clk,
        output busy,
        output con_state,
        output con_update
    );

    modport master (
        output enable,
        output pad_data,
        input  pad_latch,
        input  pad_clk,
        input  busy,
        input  con_state,
        input  con_update
    );
endinterface

// File: rtl/snes_pad_reader.sv
// Polls an SNES pad: latch pulse, 16 serial bits, atomic con_state commit.
// Optional CON_DEBOUNCE_EN: commit only when two successive raw frames agree.
module snes_pad_reader #(
    parameter int HALF_CYC = 300,
    parameter int POLL_CYC = 833333
) (
    input  logic       clk,
    input  logic       rst_n,
    snes_pad_if.slave  pad
);
    localparam int PW = $clog2(POLL_CYC);
    localparam int CW = $clog2(2 * HALF_CYC);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   con_state_q, con_state_d;
    logic          con_update_q, con_update_d;
    logic          pad_latch_q, pad_latch_d;
    logic          pad_clk_q, pad_clk_d;
    logic          busy_q, busy_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
`ifdef CON_DEBOUNCE_EN
    logic [15:0]   prev_q, prev_d;
`endif
    logic          tick;

    assign tick = (poll_q == PW'(POLL_CYC - 1));

    // Next-state, frame sequencing and registered pad outputs
    always_comb begin
        state_d      = state_q;
        poll_d       = tick ? '0 : poll_q + PW'(1);
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        con_state_d  = con_state_q;
        con_update_d = 1'b0;
        sync1_d      = pad.pad_data;
        sync2_d      = sync1_q;
`ifdef CON_DEBOUNCE_EN
        prev_d       = prev_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (tick && pad.enable) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end
            end
            LATCH: begin
                if (cnt_q == CW'(2 * HALF_CYC - 1)) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOW: begin
                if (cnt_q == CW'(HALF_CYC - 1)) begin
                    shift_d[idx_q] = ~sync2_q;
                    state_d        = HIGH;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (cnt_q == CW'(HALF_CYC - 1)) begin
                    cnt_d = '0;
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = LOW;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
`ifdef CON_DEBOUNCE_EN
                if (shift_q == prev_q) begin
                    con_state_d  = shift_q;
                    con_update_d = 1'b1;
                end
                prev_d = shift_q;
`else
                con_state_d  = shift_q;
                con_update_d = 1'b1;
`endif
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pad_latch_d = (state_d == LATCH);
        pad_clk_d   = (state_d != LOW);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            poll_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            con_state_q  <= '0;
            con_update_q <= 1'b0;
            pad_latch_q  <= 1'b0;
            pad_clk_q    <= 1'b1;
            busy_q       <= 1'b0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
`ifdef CON_DEBOUNCE_EN
            prev_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            poll_q       <= poll_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            con_state_q  <= con_state_d;
            con_update_q <= con_update_d;
            pad_latch_q  <= pad_latch_d;
            pad_clk_q    <= pad_clk_d;
            busy_q       <= busy_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
`ifdef CON_DEBOUNCE_EN
            prev_q       <= prev_d;
`endif
        end
    end

    assign pad.pad_latch  = pad_latch_q;
    assign pad.pad_clk    = pad_clk_q;
    assign pad.busy       = busy_q;
    assign pad.con_state  = con_state_q;
    assign pad.con_update = con_update_q;
endmodule

// File: tb/tb_snes_pad_reader.sv
// Directed bench for snes_pad_reader with a behavioural 4021-style pad.
// HALF_CYC=4, POLL_CYC=200.
module tb_snes_pad_reader;
`ifdef CON_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    snes_pad_if pif ();

    snes_pad_reader #(
        .HALF_CYC(4),
        .POLL_CYC(200)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pad  (pif.slave)
    );

    // Pad model: latch reloads, each pad_clk rise shifts to the next bit
    logic [15:0] pad_buttons;
    logic        unplug;
    int          pidx = 0;

    always @(posedge pif.pad_latch or posedge pif.pad_clk) begin
        if (pif.pad_latch) pidx = 0;
        else if (pidx < 16) pidx = pidx + 1;
    end

    assign pif.pad_data = unplug ? 1'b1 :
                          (pidx < 16) ? ~pad_buttons[pidx[3:0]] : 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of what con_state should hold
    logic [15:0] exp_state;
    logic [15:0] prev_raw;
    int          exp_ups;

    task automatic model_reset();
        exp_state = '0;
        prev_raw  = '0;
    endtask

    task automatic model_frame(input logic [15:0] raw);
        if (!DEB || raw == prev_raw) begin
            exp_state = raw;
            exp_ups   = exp_ups + 1;
        end
        prev_raw = raw;
    endtask

    // Window observation counters
    int w_lat_cnt, w_lat_off, w_lat_hi, w_clk_fall, w_clk_lo;
    int w_busy, w_upd, w_done_off;

    task automatic watch(input int n);
        logic pl, pc, pb;
        pl = pif.pad_latch;
        pc = pif.pad_clk;
        pb = pif.busy;
        w_lat_cnt = 0; w_lat_off = -1; w_lat_hi = 0; w_clk_fall = 0;
        w_clk_lo = 0; w_busy = 0; w_upd = 0; w_done_off = -1;
        for (int t = 1; t <= n; t++) begin
            @(posedge clk);
            #1;
            if (!pl && pif.pad_latch) begin
                w_lat_cnt++;
                if (w_lat_off < 0) w_lat_off = t;
            end
            if (pif.pad_latch) w_lat_hi++;
            if (pc && !pif.pad_clk) w_clk_fall++;
            if (!pif.pad_clk) w_clk_lo++;
            if (pif.busy) w_busy++;
            if (pb && !pif.busy && w_done_off < 0) w_done_off = t;
            if (pif.con_update) w_upd++;
            pl = pif.pad_latch;
            pc = pif.pad_clk;
            pb = pif.busy;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        n_tests++;
        if (pif.pad_latch !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_latch: got %b want 0", pif.pad_latch);
        end
        n_tests++;
        if (pif.pad_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_padclk: got %b want 1", pif.pad_clk);
        end
        n_tests++;
        if (pif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: got %b want 0", pif.busy);
        end
        n_tests++;
        if (pif.con_state !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_state: got %h want 0000", pif.con_state);
        end
        n_tests++;
        if (pif.con_update !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_update: got %b want 0", pif.con_update);
        end
    endtask

    task automatic test_first_frame();
        int ups0;
        ups0 = exp_ups;
        rst_n = 1'b1;
        watch(340);
        model_frame(16'h0A05);
        n_tests++;
        if (w_lat_off !== 200) begin
            n_fail++;
            $display("FAIL ff_latch_off: got %0d want 200", w_lat_off);
        end
        n_tests++;
        if (w_lat_hi !== 8) begin
            n_fail++;
            $display("FAIL ff_latch_len: got %0d want 8", w_lat_hi);
        end
        n_tests++;
        if (w_clk_fall !== 16) begin
            n_fail++;
            $display("FAIL ff_clk_pulses: got %0d want 16", w_clk_fall);
        end
        n_tests++;
        if (w_clk_lo !== 64) begin
            n_fail++;
            $display("FAIL ff_clk_low: got %0d want 64", w_clk_lo);
        end
        n_tests++;
        if (w_busy !== 137) begin
            n_fail++;
            $display("FAIL ff_busy_len: got %0d want 137", w_busy);
        end
        n_tests++;
        if (w_done_off - w_lat_off !== 137) begin
            n_fail++;
            $display("FAIL ff_done_off: got %0d want 137",
                     w_done_off - w_lat_off);
        end
        n_tests++;
        if (w_upd !== exp_ups - ups0) begin
            n_fail++;
            $display("FAIL ff_updates: got %0d want %0d", w_upd, exp_ups - ups0);
        end
        n_tests++;
        if (pif.con_state !== exp_state) begin
            n_fail++;
            $display("FAIL ff_state: got %h want %h", pif.con_state, exp_state);
        end
    endtask

    task automatic test_disable();
        pif.enable = 1'b0;
        watch(1000);
        n_tests++;
        if (w_lat_cnt !== 0) begin
            n_fail++;
            $display("FAIL dis_latch: got %0d rises want 0", w_lat_cnt);
        end
        n_tests++;
        if (w_busy !== 0) begin
            n_fail++;
            $display("FAIL dis_busy: got %0d busy cycles want 0", w_busy);
        end
        n_tests++;
        if (pif.con_state !== exp_state) begin
            n_fail++;
            $display("FAIL dis_hold: got %h want %h", pif.con_state, exp_state);
        end
    endtask

    task automatic test_enable_drop();
        int   falls;
        bit   found;
        logic pc;
        int   ups0;
        pad_buttons = 16'h1234;
        pif.enable  = 1'b1;
        falls = 0;
        found = 1'b0;
        pc    = pif.pad_clk;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            if (pc && !pif.pad_clk) falls++;
            pc = pif.pad_clk;
            if (falls == 6) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL drop_wait: got %0d falls want 6", falls);
        end
        pif.enable = 1'b0;
        ups0 = exp_ups;
        watch(600);
        model_frame(16'h1234);
        n_tests++;
        if (w_upd !== exp_ups - ups0) begin
            n_fail++;
            $display("FAIL drop_updates: got %0d want %0d", w_upd, exp_ups - ups0);
        end
        n_tests++;
        if (pif.con_state !== exp_state) begin
            n_fail++;
            $display("FAIL drop_state: got %h want %h", pif.con_state, exp_state);
        end
        n_tests++;
        if (w_lat_cnt !== 0) begin
            n_fail++;
            $display("FAIL drop_relatch: got %0d rises want 0", w_lat_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int   falls;
        bit   found;
        logic pc;
        int   ups0;
        pad_buttons = 16'h00FF;
        pif.enable  = 1'b1;
        falls = 0;
        found = 1'b0;
        pc    = pif.pad_clk;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            if (pc && !pif.pad_clk) falls++;
            pc = pif.pad_clk;
            if (falls == 8) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL mr_wait: got %0d falls want 8", falls);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (pif.pad_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_padclk: got %b want 1", pif.pad_clk);
        end
        n_tests++;
        if (pif.pad_latch !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_latch: got %b want 0", pif.pad_latch);
        end
        n_tests++;
        if (pif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_busy: got %b want 0", pif.busy);
        end
        n_tests++;
        if (pif.con_state !== 16'h0000) begin
            n_fail++;
            $display("FAIL mr_state: got %h want 0000", pif.con_state);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ups0 = exp_ups;
        watch(360);
        model_frame(16'h00FF);
        n_tests++;
        if (w_lat_off !== 200) begin
            n_fail++;
            $display("FAIL mr_relatch: got %0d want 200", w_lat_off);
        end
        n_tests++;
        if (w_upd !== exp_ups - ups0) begin
            n_fail++;
            $display("FAIL mr_updates: got %0d want %0d", w_upd, exp_ups - ups0);
        end
        n_tests++;
        if (pif.con_state !== exp_state) begin
            n_fail++;
            $display("FAIL mr_frame: got %h want %h", pif.con_state, exp_state);
        end
    endtask

    task automatic test_unplugged();
        int ups0;
        unplug = 1'b1;
        ups0 = exp_ups;
        watch(400);
        model_frame(16'h0000);
        model_frame(16'h0000);
        n_tests++;
        if (w_lat_cnt !== 2) begin
            n_fail++;
            $display("FAIL unp_frames: got %0d want 2", w_lat_cnt);
        end
        n_tests++;
        if (w_upd !== exp_ups - ups0) begin
            n_fail++;
            $display("FAIL unp_updates: got %0d want %0d", w_upd, exp_ups - ups0);
        end
        n_tests++;
        if (pif.con_state !== exp_state) begin
            n_fail++;
            $display("FAIL unp_state: got %h want %h", pif.con_state, exp_state);
        end
        unplug = 1'b0;
    endtask

    task automatic test_debounce();
        logic [15:0] frames [3];
        bit          ok;
        logic        upd;
        int          ups0;
        int          strobes;
        frames[0] = 16'h0001;
        frames[1] = 16'h0003;
        frames[2] = 16'h0003;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int f = 0; f < 3; f++) begin
            pad_buttons = frames[f];
            ups0 = exp_ups;
            strobes = 0;
            ok = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(posedge clk);
                #1;
                if (pif.con_update) strobes++;
                if (pif.busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            upd = 1'b0;
            if (ok) begin
                ok = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    @(posedge clk);
                    #1;
                    if (pif.con_update) strobes++;
                    if (!pif.busy) begin
                        upd = pif.con_update;
                        ok  = 1'b1;
                        break;
                    end
                end
            end
            model_frame(frames[f]);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL deb_wait%0d: frame did not complete", f);
            end
            n_tests++;
            if (strobes !== exp_ups - ups0 || upd !== (exp_ups != ups0)) begin
                n_fail++;
                $display("FAIL deb_strobe%0d: got %0d (at end %b) want %0d",
                         f, strobes, upd, exp_ups - ups0);
            end
            n_tests++;
            if (pif.con_state !== exp_state) begin
                n_fail++;
                $display("FAIL deb_state%0d: got %h want %h",
                         f, pif.con_state, exp_state);
            end
        end
    endtask

    initial begin
        exp_ups     = 0;
        unplug      = 1'b0;
        pad_buttons = 16'h0A05;
        pif.enable  = 1'b1;
        test_reset();
        test_first_frame();
        test_disable();
        test_enable_drop();
        test_mid_reset();
        test_unplugged();
        test_debounce();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
